// File: rtl/b01_word_collector.sv
// b01_word_collector
//   Serial-to-parallel collector placed after the b01 serial FSM. It gathers
//   WIDTH qualified bits LSB-first into a word and offers the word to a
//   consumer on a valid/ready port. It also keeps a sticky overrun flag and a
//   saturating count of overflow bits.
//
//   Optional feature macro: B01_COLLECT_OVFCNT_EN
//     defined   -> ovf_count is a saturating counter of qualified overflow bits
//     undefined -> no counter is built and ovf_count is tied to 0
//
// Parameters
//   WIDTH        bits per assembled word (minimum 2)
//   CNT_W        width of the overflow-event counter
// Ports
//   clock        clock; every state update happens on its rising edge
//   RESET_G      asynchronous active-high reset
//   OUTP_REG     serial data bit from the b01 stage
//   OVERFLW_REG  overflow flag from the b01 stage, aligned with OUTP_REG
//   bit_valid    qualifies OUTP_REG/OVERFLW_REG this cycle
//   sync_clr     frame realign; discards the partial word
//   word_ready   consumer accepts the held word this cycle
//   word_valid   holding register contains a word
//   word_data    assembled word, bit 0 is the first bit received
//   word_ovf     OR of OVERFLW_REG over the bits of word_data
//   overrun      sticky; a completed word was dropped
//   overrun_clr  synchronous clear of overrun (a set in the same cycle wins)
//   ovf_count    saturating count of qualified overflow bits

module b01_word_collector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             RESET_G,
    input  logic             OUTP_REG,
    input  logic             OVERFLW_REG,
    input  logic             bit_valid,
    input  logic             sync_clr,
    input  logic             word_ready,
    output logic             word_valid,
    output logic [WIDTH-1:0] word_data,
    output logic             word_ovf,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int BW = $clog2(WIDTH);

    typedef enum logic {C_IDLE, C_SHIFT} cstate_t;
    typedef enum logic {O_EMPTY, O_FULL} ostate_t;

    cstate_t          cstate, cstate_n;
    logic [BW-1:0]    bcnt, bcnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             acc, acc_n;
    logic             complete;
    logic             new_ovf;

    ostate_t          ostate, ostate_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             ovf_q, ovf_n;
    logic             overrun_q, overrun_n;
    logic             ovr_set;

    always_ff @(posedge clock or posedge RESET_G) begin
        if (RESET_G) begin
            cstate    <= C_IDLE;
            bcnt      <= '0;
            shreg     <= '0;
            acc       <= 1'b0;
            ostate    <= O_EMPTY;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cstate    <= cstate_n;
            bcnt      <= bcnt_n;
            shreg     <= shreg_n;
            acc       <= acc_n;
            ostate    <= ostate_n;
            data_q    <= data_n;
            ovf_q     <= ovf_n;
            overrun_q <= overrun_n;
        end
    end

    // Collector: bcnt is 0 in IDLE, so the write at position bcnt serves both
    // states. The completing word is taken from shreg_n, which already holds
    // the final bit.
    always_comb begin
        cstate_n = cstate;
        bcnt_n   = bcnt;
        shreg_n  = shreg;
        acc_n    = acc;
        complete = 1'b0;
        new_ovf  = acc | OVERFLW_REG;
        if (sync_clr) begin
            cstate_n = C_IDLE;
            bcnt_n   = '0;
            acc_n    = 1'b0;
        end else if (bit_valid) begin
            shreg_n[bcnt] = OUTP_REG;
            if (cstate == C_SHIFT && bcnt == BW'(WIDTH - 1)) begin
                complete = 1'b1;
                cstate_n = C_IDLE;
                bcnt_n   = '0;
                acc_n    = 1'b0;
            end else begin
                cstate_n = C_SHIFT;
                bcnt_n   = bcnt + BW'(1);
                acc_n    = new_ovf;
            end
        end
    end

    // Output holding register: a consume and a new completion in the same
    // cycle reload directly so word_valid has no bubble.
    always_comb begin
        ostate_n = ostate;
        data_n   = data_q;
        ovf_n    = ovf_q;
        ovr_set  = 1'b0;
        case (ostate)
            O_EMPTY: begin
                if (complete) begin
                    ostate_n = O_FULL;
                    data_n   = shreg_n;
                    ovf_n    = new_ovf;
                end
            end
            O_FULL: begin
                if (word_ready) begin
                    if (complete) begin
                        data_n = shreg_n;
                        ovf_n  = new_ovf;
                    end else begin
                        ostate_n = O_EMPTY;
                    end
                end else if (complete) begin
                    ovr_set = 1'b1;
                end
            end
            default: ostate_n = O_EMPTY;
        endcase
        overrun_n = ovr_set | (overrun_q & ~overrun_clr);
    end

    assign word_valid = (ostate == O_FULL);
    assign word_data  = data_q;
    assign word_ovf   = ovf_q;
    assign overrun    = overrun_q;

`ifdef B01_COLLECT_OVFCNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts every qualified overflow bit, including ones discarded by sync_clr.
    always_ff @(posedge clock or posedge RESET_G) begin
        if (RESET_G) begin
            cnt_q <= '0;
        end else if (bit_valid && OVERFLW_REG && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign ovf_count = cnt_q;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_b01_word_collector.sv
module tb_b01_word_collector;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          RESET_G;
    logic          OUTP_REG;
    logic          OVERFLW_REG;
    logic          bit_valid;
    logic          sync_clr;
    logic          word_ready;
    logic          word_valid;
    logic [W-1:0]  word_data;
    logic          word_ovf;
    logic          overrun;
    logic          overrun_clr;
    logic [CW-1:0] ovf_count;

    int tests  = 0;
    int failed = 0;

    b01_word_collector #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock       (clock),
        .RESET_G     (RESET_G),
        .OUTP_REG    (OUTP_REG),
        .OVERFLW_REG (OVERFLW_REG),
        .bit_valid   (bit_valid),
        .sync_clr    (sync_clr),
        .word_ready  (word_ready),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_ovf    (word_ovf),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .ovf_count   (ovf_count)
    );

    always #5 clock = ~clock;

    `ifdef B01_COLLECT_OVFCNT_EN
    localparam bit CNT_ON = 1'b1;
    `else
    localparam bit CNT_ON = 1'b0;
    `endif

    // Behavioural model: a queue of received bits, one held word.
    logic          mq[$];
    logic          m_pacc;
    logic [W-1:0]  m_data;
    logic          m_ovf;
    logic          m_valid;
    logic          m_overrun;
    int            m_cnt;

    always @(posedge clock or posedge RESET_G) begin
        logic          done;
        logic [W-1:0]  w;
        logic          wovf;
        logic          set_ovr;
        if (RESET_G) begin
            mq.delete();
            m_pacc = 1'b0; m_data = '0; m_ovf = 1'b0;
            m_valid = 1'b0; m_overrun = 1'b0; m_cnt = 0;
        end else begin
            done = 1'b0; w = '0; wovf = 1'b0; set_ovr = 1'b0;
            if (CNT_ON && bit_valid && OVERFLW_REG && m_cnt < (1 << CW) - 1)
                m_cnt = m_cnt + 1;
            if (sync_clr) begin
                mq.delete();
                m_pacc = 1'b0;
            end else if (bit_valid) begin
                mq.push_back(OUTP_REG);
                m_pacc = m_pacc | OVERFLW_REG;
                if (mq.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = mq[i];
                    wovf = m_pacc;
                    done = 1'b1;
                    mq.delete();
                    m_pacc = 1'b0;
                end
            end
            if (m_valid && word_ready) m_valid = 1'b0;
            if (done) begin
                if (!m_valid) begin
                    m_valid = 1'b1; m_data = w; m_ovf = wovf;
                end else begin
                    set_ovr = 1'b1;
                end
            end
            m_overrun = set_ovr | (m_overrun & ~overrun_clr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (!RESET_G) begin
            check("valid", 32'(word_valid), 32'(m_valid));
            check("overrun", 32'(overrun), 32'(m_overrun));
            check("ovf_count", 32'(ovf_count), 32'(m_cnt));
            if (m_valid) begin
                check("data", 32'(word_data), 32'(m_data));
                check("ovf", 32'(word_ovf), 32'(m_ovf));
            end
        end
    end

    task automatic send_bit(input logic b, input logic o);
        OUTP_REG = b; OVERFLW_REG = o; bit_valid = 1'b1;
        @(negedge clock);
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic [W-1:0] om);
        for (int i = 0; i < W; i++) send_bit(w[i], om[i]);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        RESET_G = 1'b1; OUTP_REG = 1'b0; OVERFLW_REG = 1'b0; bit_valid = 1'b0;
        sync_clr = 1'b0; word_ready = 1'b0; overrun_clr = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_data", 32'(word_data), 32'd0);
        check("rst_ovf", 32'(word_ovf), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_count", 32'(ovf_count), 32'd0);
        RESET_G = 1'b0;
        idle(1);

        // Basic word, consumer always ready
        word_ready = 1'b1;
        send_word(8'h8D, 8'h00);
        check("w8d_valid", 32'(word_valid), 32'd1);
        check("w8d_data", 32'(word_data), 32'h8D);
        check("w8d_ovf", 32'(word_ovf), 32'd0);
        idle(2);

        // Overflow on bit 3 only
        send_word(8'h8D, 8'h08);
        check("ovf_data", 32'(word_data), 32'h8D);
        check("ovf_flag", 32'(word_ovf), 32'd1);
        check("ovf_cnt1", 32'(ovf_count), CNT_ON ? 32'd1 : 32'd0);
        idle(2);

        // Overrun: second word dropped while not ready
        word_ready = 1'b0;
        send_word(8'hA5, 8'h00);
        send_word(8'h3C, 8'h00);
        idle(1);
        check("ovr_data", 32'(word_data), 32'hA5);
        check("ovr_flag", 32'(overrun), 32'd1);
        word_ready = 1'b1;
        idle(1);
        word_ready = 1'b0;
        check("ovr_consumed", 32'(word_valid), 32'd0);
        overrun_clr = 1'b1;
        idle(1);
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // Consume and reload in the same cycle
        send_word(8'h11, 8'h00);
        for (int i = 0; i < W - 1; i++) send_bit(1'(8'h22 >> i), 1'b0);
        word_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        check("b2b_data", 32'(word_data), 32'h22);
        check("b2b_valid", 32'(word_valid), 32'd1);
        check("b2b_overrun", 32'(overrun), 32'd0);
        idle(1);

        // sync_clr discards a partial word and the bit alongside it
        repeat (3) send_bit(1'b0, 1'b0);
        sync_clr = 1'b1;
        send_bit(1'b0, 1'b0);
        sync_clr = 1'b0;
        check("sclr_novalid", 32'(word_valid), 32'd0);
        send_word(8'hFF, 8'h00);
        check("sclr_data", 32'(word_data), 32'hFF);
        idle(2);

        // Saturation: 256 overflow bits
        repeat (32) send_word(8'h00, 8'hFF);
        idle(1);
        check("sat_count", 32'(ovf_count), CNT_ON ? 32'd255 : 32'd0);

        // Asynchronous reset mid-word while a word is held
        word_ready = 1'b0;
        send_word(8'h5A, 8'h00);
        repeat (4) send_bit(1'b1, 1'b0);
        #2 RESET_G = 1'b1;
        #1;
        check("arst_valid", 32'(word_valid), 32'd0);
        check("arst_data", 32'(word_data), 32'd0);
        check("arst_ovf", 32'(word_ovf), 32'd0);
        check("arst_overrun", 32'(overrun), 32'd0);
        check("arst_count", 32'(ovf_count), 32'd0);
        @(negedge clock);
        RESET_G = 1'b0;
        word_ready = 1'b1;
        send_word(8'h01, 8'h00);
        check("post_rst_data", 32'(word_data), 32'h01);
        check("post_rst_valid", 32'(word_valid), 32'd1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/b01_word_collector.md
# b01_word_collector

Serial-to-parallel result collector directly downstream of the b01 serial FSM. It samples the FSM's registered `OUTP_REG` and `OVERFLW_REG` outputs, assembles `WIDTH` qualified bits LSB-first into a word, and presents the word on a valid/ready port to the consumer. It also keeps a sticky overrun flag and a saturating count of overflow bits.

## Interface
- `WIDTH`, 8: bits per assembled word; minimum 2.
- `CNT_W`, 8: width of the overflow-event counter.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `RESET_G`  in  1  asynchronous, active-high reset.
- `OUTP_REG`  in  1  serial data bit from the b01 stage.
- `OVERFLW_REG`  in  1  overflow flag from the b01 stage, aligned with `OUTP_REG`.
- `bit_valid`  in  1  qualifies `OUTP_REG`/`OVERFLW_REG` this cycle.
- `sync_clr`  in  1  synchronous frame realign; discards the partial word.
- `word_ready`  in  1  consumer accepts the word this cycle.
- `word_valid`  out  1  holding register contains a word.
- `word_data`  out  WIDTH  assembled word; bit 0 is the first bit received.
- `word_ovf`  out  1  OR of `OVERFLW_REG` over the bits of `word_data`.
- `overrun`  out  1  sticky; a completed word was dropped.
- `overrun_clr`  in  1  synchronous clear of `overrun`.
- `ovf_count`  out  CNT_W  saturating count of qualified overflow bits.

## Operation
- Collector FSM has two states, IDLE and SHIFT, plus a bit counter `bcnt` of width clog2(WIDTH).
  - IDLE: `bcnt`=0. A `bit_valid` moves the FSM to SHIFT and stores the bit at position 0.
  - SHIFT: each `bit_valid` stores `OUTP_REG` at position `bcnt` and increments `bcnt`. The partial-ovf accumulator ORs in `OVERFLW_REG`.
  - The bit with `bcnt`=WIDTH-1 completes the word. That cycle the FSM returns to IDLE, clears `bcnt` and the accumulator, and raises a completion strobe.
- Output FSM has two states, EMPTY and FULL, and holds `word_data`, `word_ovf` and `word_valid`.
  - Completion while EMPTY: load the word and go to FULL.
  - Handshake: in FULL with `word_ready`=1, the word is consumed at that edge.
  - Completion while FULL and `word_ready`=1 in the same cycle: load the new word and stay FULL. `word_valid` stays high with no bubble.
  - Completion while FULL and `word_ready`=0: drop the new word, keep the held word unchanged, set `overrun`.
  - `word_ready` while EMPTY is ignored.
  - `word_data` and `word_ovf` remain stable while `word_valid`=1 and `word_ready`=0.
- `sync_clr` returns the collector to IDLE with `bcnt`=0 and the accumulator cleared. It overrides a `bit_valid` in the same cycle, so that bit is discarded. It does not affect the output FSM, `overrun` or `ovf_count`.
- `overrun`: when set and `overrun_clr` occur in the same cycle, set wins.
- `ovf_count`: increments on `bit_valid`=1 and `OVERFLW_REG`=1 (bits discarded by `sync_clr` are still counted). Saturates at 2^CNT_W-1. Cleared only by reset.
- Reset mid-word discards the partial word and the held word.

## Timing
- Reset values: `word_valid`=0, `word_data`=0, `word_ovf`=0, `overrun`=0, `ovf_count`=0. Collector in IDLE, output FSM in EMPTY.
- Latency: `word_valid` rises on the clock edge following the WIDTH-th qualified bit, i.e. 1 cycle.
- Throughput: one bit per cycle. A word can be consumed every WIDTH cycles without overrun if `word_ready` is asserted within WIDTH-1 cycles of `word_valid` rising.
- `overrun` is set at the same edge at which the dropped word would have loaded.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `B01_COLLECT_OVFCNT_EN`:
  - Defined: the `ovf_count` register and its saturating incrementer are built as described above.
  - Undefined: no counter logic is built, and `ovf_count` is driven constant 0. All other behaviour is unchanged.

## Test plan
- WIDTH=8, `word_ready`=1, serial bits 1,0,1,1,0,0,0,1 with `OVERFLW_REG`=0 -> `word_data`=8'h8D and `word_ovf`=0, with `word_valid` high one cycle after the 8th bit.
- Same word with `OVERFLW_REG`=1 on bit 3 only -> `word_ovf`=1. `ovf_count` 0->1 with macro defined; stays 0 with it undefined.
- `word_ready`=0, two full words 8'hA5 then 8'h3C -> `word_data` stays 8'hA5 and `overrun`=1. Pulse `word_ready` -> `word_valid`=0. Pulse `overrun_clr` -> `overrun`=0.
- Second word completes in the same cycle `word_ready`=1 consumes 8'h11 -> `word_data` becomes 8'h22, `word_valid` never drops, `overrun`=0.
- 3 bits, then `sync_clr` together with a 4th `bit_valid`, then bits for 8'hFF -> `word_data`=8'hFF and no earlier word is emitted.
- Assert `RESET_G` asynchronously mid-word with `word_valid`=1 -> all outputs 0 immediately. After release, the next 8 bits 8'h01 -> `word_data`=8'h01.
